// File: rtl/miner_pkg.sv
// Shared definitions for the mining datapath (hash core, comparator, nonce sequencer).
// Contents: sequencer state encoding, default nonce/hash widths, busy-state helper.
// No ports; imported with "import miner_pkg::*".
package miner_pkg;

    localparam int NONCE_W_DEF = 32;
    localparam int HASH_W_DEF  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // ISSUE and WAIT together make up an in-flight search.
    function automatic logic state_is_busy(input seq_state_e s);
        return (s == ISSUE) || (s == WAIT);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Response watchdog: counts cycles spent waiting for a comparator verdict.
// Ports: clk, reset (sync, active-low), clr_i (zero the count), en_i (advance by one),
//        expired_o (count has reached TIMEOUT_CYC-1; combinational from the count).
module seq_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/nonce_sequencer.sv
// Nonce sequencer: issues nonces to the hash core and reacts to the comparator's verdicts
// until a hit, range exhaustion, response timeout or abort.
// Ports: clk, reset (sync, active-low); start/abort control; nonce_base/nonce_last range;
//        valid/next/h from the comparator; nonce/hash_start to the hash core;
//        busy/found/exhausted/timeout status; found_nonce/found_hash result.
// Optional: define NONCE_SEQ_STATS_EN to add the saturating 'attempts' verdict counter port.
module nonce_sequencer
    import miner_pkg::*;
#(
    parameter int NONCE_W     = NONCE_W_DEF,
    parameter int HASH_W      = HASH_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_base,
    input  logic [NONCE_W-1:0] nonce_last,
    input  logic               valid,
    input  logic               next,
    input  logic [HASH_W-1:0]  h,
    output logic [NONCE_W-1:0] nonce,
    output logic               hash_start,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               timeout,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [HASH_W-1:0]  found_hash
`ifdef NONCE_SEQ_STATS_EN
    ,
    output logic [NONCE_W-1:0] attempts
`endif
);

    seq_state_e         state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] last_q, last_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic               timeout_q, timeout_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic [HASH_W-1:0]  found_hash_q, found_hash_d;

    logic launch;
    logic verdict;
    logic wd_clr;
    logic wd_en;
    logic wd_expired;

    seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // A start is only honoured when idle or done, and abort always wins over it.
    assign launch  = start && !abort && ((state_q == IDLE) || (state_q == DONE));
    assign verdict = (state_q == WAIT) && (valid || next);

    always_comb begin
        state_d       = state_q;
        nonce_d       = nonce_q;
        last_d        = last_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        timeout_d     = timeout_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;

        case (state_q)
            ISSUE: begin
                wd_clr  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (valid) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                    found_hash_d  = h;
                    state_d       = DONE;
                end else if (next && (nonce_q == last_q)) begin
                    exhausted_d = 1'b1;
                    state_d     = DONE;
                end else if (next) begin
                    // Wraps naturally through all-ones to zero.
                    nonce_d = nonce_q + NONCE_W'(1);
                    state_d = ISSUE;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wd_en = 1'b1;
                end
            end
            default: ;
        endcase

        if (launch) begin
            nonce_d     = nonce_base;
            last_d      = nonce_last;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            timeout_d   = 1'b0;
            state_d     = ISSUE;
        end

        // Abort drops the status flags but leaves the last result readable.
        if (abort) begin
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            timeout_d   = 1'b0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            nonce_q       <= '0;
            last_q        <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            timeout_q     <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            last_q        <= last_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            timeout_q     <= timeout_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
        end
    end

    assign nonce       = nonce_q;
    assign hash_start  = (state_q == ISSUE);
    assign busy        = state_is_busy(state_q);
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign timeout     = timeout_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;

`ifdef NONCE_SEQ_STATS_EN
    logic [NONCE_W-1:0] attempts_q, attempts_d;

    always_comb begin
        attempts_d = attempts_q;
        if (launch) begin
            attempts_d = '0;
        end else if (verdict && (attempts_q != '1)) begin
            attempts_d = attempts_q + NONCE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            attempts_q <= '0;
        end else begin
            attempts_q <= attempts_d;
        end
    end

    assign attempts = attempts_q;
`else
    // Verdict tracking only feeds the optional counter.
    logic unused_verdict;
    assign unused_verdict = verdict;
`endif

endmodule

// File: tb/tb_nonce_sequencer.sv
// Directed bench for nonce_sequencer with TIMEOUT_CYC=8.
// Inputs are driven and outputs sampled on the falling clock edge.
// Each scenario is a task with its own inline comparisons.
module tb_nonce_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] nonce_base = '0;
    logic [31:0] nonce_last = '0;
    logic        valid = 1'b0;
    logic        next = 1'b0;
    logic [23:0] h = '0;
    logic [31:0] nonce;
    logic        hash_start;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic        timeout;
    logic [31:0] found_nonce;
    logic [23:0] found_hash;
`ifdef NONCE_SEQ_STATS_EN
    logic [31:0] attempts;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] issued_q[$];

    always #5 clk = ~clk;

    nonce_sequencer #(
        .NONCE_W     (32),
        .HASH_W      (24),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .nonce_base  (nonce_base),
        .nonce_last  (nonce_last),
        .valid       (valid),
        .next        (next),
        .h           (h),
        .nonce       (nonce),
        .hash_start  (hash_start),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .timeout     (timeout),
        .found_nonce (found_nonce),
        .found_hash  (found_hash)
`ifdef NONCE_SEQ_STATS_EN
        ,
        .attempts    (attempts)
`endif
    );

    // Pulse start for one cycle; returns at the falling edge of the ISSUE cycle.
    task automatic launch(input logic [31:0] b, input logic [31:0] l);
        @(negedge clk);
        nonce_base = b;
        nonce_last = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Comparator stand-in: answers every WAIT cycle until the sequencer leaves busy.
    task automatic run_search(input logic [31:0] hit_n, input bit use_hit, input bit give_next,
                              input logic [23:0] hv, output int pulses, output int waits,
                              output bit expired);
        pulses = 0;
        waits = 0;
        expired = 1'b1;
        issued_q.delete();
        for (int c = 0; c < 200; c++) begin
            if (!busy) begin
                expired = 1'b0;
                break;
            end
            if (hash_start) begin
                pulses++;
                issued_q.push_back(nonce);
                valid = 1'b0;
                next = 1'b0;
            end else begin
                waits++;
                valid = use_hit && (nonce == hit_n);
                next = give_next;
                h = hv;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        next = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({nonce, hash_start, busy, found, exhausted, timeout, found_nonce, found_hash} !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: nonce=%h hs=%b busy=%b f=%b e=%b t=%b fn=%h fh=%h, required all 0",
                         i, nonce, hash_start, busy, found, exhausted, timeout, found_nonce, found_hash);
            end
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || hash_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b hash_start=%b, required 0 0", busy, hash_start);
        end
    endtask

    task automatic test_hit();
        int pulses, waits;
        bit expired;
        launch(32'd5, 32'd20);
        run_search(32'd7, 1'b1, 1'b1, 24'h0A0B0C, pulses, waits, expired);
        tests_run++;
        if (expired || pulses != 3) begin
            tests_failed++;
            $display("FAIL hit_pulses: got %0d (budget expired=%0d), required 3", pulses, expired);
        end
        tests_run++;
        if (found !== 1'b1 || exhausted !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL hit_flags: found=%b exh=%b to=%b busy=%b, required 1 0 0 0", found, exhausted, timeout, busy);
        end
        tests_run++;
        if (found_nonce !== 32'd7 || found_hash !== 24'h0A0B0C) begin
            tests_failed++;
            $display("FAIL hit_result: nonce=%h hash=%h, required 00000007 0a0b0c", found_nonce, found_hash);
        end
`ifdef NONCE_SEQ_STATS_EN
        tests_run++;
        if (attempts !== 32'd3) begin
            tests_failed++;
            $display("FAIL hit_attempts: got %0d, required 3", attempts);
        end
`endif
    endtask

    task automatic test_exhaust_wrap();
        int pulses, waits;
        bit expired;
        launch(32'hFFFF_FFFE, 32'h1);
        run_search(32'h0, 1'b0, 1'b1, 24'h0, pulses, waits, expired);
        tests_run++;
        if (expired || issued_q.size() != 4) begin
            tests_failed++;
            $display("FAIL wrap_count: issued %0d (budget expired=%0d), required 4", issued_q.size(), expired);
        end else begin
            tests_run++;
            if (issued_q[0] !== 32'hFFFF_FFFE || issued_q[1] !== 32'hFFFF_FFFF ||
                issued_q[2] !== 32'h0 || issued_q[3] !== 32'h1) begin
                tests_failed++;
                $display("FAIL wrap_seq: got %h %h %h %h, required fffffffe ffffffff 00000000 00000001",
                         issued_q[0], issued_q[1], issued_q[2], issued_q[3]);
            end
        end
        tests_run++;
        if (exhausted !== 1'b1 || found !== 1'b0 || timeout !== 1'b0 || nonce !== 32'h1) begin
            tests_failed++;
            $display("FAIL wrap_done: exh=%b found=%b to=%b nonce=%h, required 1 0 0 00000001",
                     exhausted, found, timeout, nonce);
        end
    endtask

    task automatic test_priority_timeout();
        int pulses, waits;
        bit expired;
        launch(32'd100, 32'd200);
        run_search(32'd100, 1'b1, 1'b1, 24'h123456, pulses, waits, expired);
        tests_run++;
        if (expired || found !== 1'b1 || exhausted !== 1'b0 || found_nonce !== 32'd100 ||
            found_hash !== 24'h123456 || pulses != 1) begin
            tests_failed++;
            $display("FAIL priority: found=%b exh=%b fn=%h fh=%h pulses=%0d, required 1 0 00000064 123456 1",
                     found, exhausted, found_nonce, found_hash, pulses);
        end
        launch(32'd0, 32'd10);
        run_search(32'd0, 1'b0, 1'b0, 24'h0, pulses, waits, expired);
        tests_run++;
        if (expired || waits != 8) begin
            tests_failed++;
            $display("FAIL timeout_cycles: waited %0d (budget expired=%0d), required 8", waits, expired);
        end
        tests_run++;
        if (timeout !== 1'b1 || busy !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_flags: to=%b busy=%b found=%b exh=%b, required 1 0 0 0",
                     timeout, busy, found, exhausted);
        end
    endtask

    task automatic test_abort_restart();
        int pulses, waits;
        bit expired;
        bit hit12;
        hit12 = 1'b0;
        launch(32'd10, 32'd50);
        for (int c = 0; c < 50; c++) begin
            next = 1'b0;
            if (busy && !hash_start && nonce == 32'd12) begin
                abort = 1'b1;
                hit12 = 1'b1;
                break;
            end
            if (busy && !hash_start) next = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (!hit12) begin
            tests_failed++;
            $display("FAIL abort_reach: nonce 12 WAIT not reached, last nonce=%h", nonce);
        end
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || hash_start !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle: busy=%b hs=%b f=%b e=%b t=%b, required all 0",
                     busy, hash_start, found, exhausted, timeout);
        end
        tests_run++;
        if (found_nonce !== 32'd100 || found_hash !== 24'h123456) begin
            tests_failed++;
            $display("FAIL abort_keep_result: fn=%h fh=%h, required 00000064 123456", found_nonce, found_hash);
        end
        // Start while busy must not disturb the running search.
        launch(32'd30, 32'd31);
        @(negedge clk);
        start = 1'b1;
        nonce_base = 32'd500;
        nonce_last = 32'd600;
        next = 1'b1;
        @(negedge clk);
        start = 1'b0;
        next = 1'b0;
        tests_run++;
        if (nonce !== 32'd31 || hash_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start: nonce=%h hs=%b, required 0000001f 1", nonce, hash_start);
        end
        @(negedge clk);
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        tests_run++;
        if (exhausted !== 1'b1 || busy !== 1'b0 || nonce !== 32'd31) begin
            tests_failed++;
            $display("FAIL busy_start_exhaust: exh=%b busy=%b nonce=%h, required 1 0 0000001f",
                     exhausted, busy, nonce);
        end
        // Restart from DONE with a single-nonce range.
        launch(32'd60, 32'd60);
        tests_run++;
        if (exhausted !== 1'b0 || busy !== 1'b1 || nonce !== 32'd60) begin
            tests_failed++;
            $display("FAIL restart_issue: exh=%b busy=%b nonce=%h, required 0 1 0000003c", exhausted, busy, nonce);
        end
        run_search(32'd60, 1'b1, 1'b0, 24'hABCDEF, pulses, waits, expired);
        tests_run++;
        if (expired || found !== 1'b1 || found_nonce !== 32'd60 || found_hash !== 24'hABCDEF || pulses != 1) begin
            tests_failed++;
            $display("FAIL restart_hit: found=%b fn=%h fh=%h pulses=%0d, required 1 0000003c abcdef 1",
                     found, found_nonce, found_hash, pulses);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_exhaust_wrap();
        test_priority_timeout();
        test_abort_restart();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
